// File: rtl/svpwm_calc_if.sv
// Start/reference/result bundle for svpwm_calc: the master drives the start request and the
// phase references, the slave returns compare values, sector code and the done pulse.
interface svpwm_calc_if;
    logic               iSV_en;
    logic signed [15:0] iV1;
    logic signed [15:0] iV2;
    logic signed [15:0] iV3;
    logic [15:0]        oTcm1;
    logic [15:0]        oTcm2;
    logic [15:0]        oTcm3;
    logic [2:0]         oSector;
    logic               oSV_done;

    modport master (
        output iSV_en, iV1, iV2, iV3,
        input  oTcm1, oTcm2, oTcm3, oSector, oSV_done
    );

    modport slave (
        input  iSV_en, iV1, iV2, iV3,
        output oTcm1, oTcm2, oTcm3, oSector, oSV_done
    );
endinterface

// File: rtl/svpwm_calc.sv
// Space-vector PWM compare-value calculator: sector detect, X/Y/Z projection, dwell-time select,
// compare generation. Define SVPWM_OVM_SCALE_EN to scale overmodulated dwell times with a divider.
module svpwm_calc #(
    parameter logic [15:0] PERIOD = 16'd5000
) (
    input  logic        iClk,
    input  logic        iRst_n,
    svpwm_calc_if.slave bus
);

    localparam logic signed [31:0] P_S = {16'd0, PERIOD};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_SEL  = 3'd2,
        S_CMP  = 3'd3,
        S_OUT  = 3'd4
`ifdef SVPWM_OVM_SCALE_EN
        , S_DIV = 3'd5
`endif
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_en_prev;
    logic               w_start;
    logic signed [15:0] r_v [3];
    logic [2:0]         r_n;
    logic signed [31:0] w_prod [3];
    logic signed [31:0] r_xyz [3];
    logic signed [31:0] w_t1_raw;
    logic signed [31:0] w_t2_raw;
    logic [15:0]        w_t1_c;
    logic [15:0]        w_t2_c;
    logic [16:0]        w_sum;
    logic               w_ovm;
    logic [15:0]        r_t1;
    logic [15:0]        r_t2;
    logic [15:0]        w_ta;
    logic [15:0]        w_tb;
    logic [15:0]        w_tc;
    logic [15:0]        r_ta;
    logic [15:0]        r_tb;
    logic [15:0]        r_tc;
    logic [15:0]        r_tcm1;
    logic [15:0]        r_tcm2;
    logic [15:0]        r_tcm3;
    logic [2:0]         r_sector;
    logic               r_done;

`ifdef SVPWM_OVM_SCALE_EN
    logic [31:0]        w_num;
    logic [16:0]        r_div_rem;
    logic [15:0]        r_div_num;
    logic [16:0]        r_div_den;
    logic [14:0]        r_div_quo;
    logic [3:0]         r_div_cnt;
    logic [17:0]        w_div_trial;
    logic [17:0]        w_div_diff;
    logic               w_div_ge;
    logic [16:0]        w_div_rem_next;
    logic [15:0]        w_div_quo_next;
`else
    logic [15:0]        w_t1_min;
`endif

    assign w_start = bus.iSV_en & ~r_en_prev;

    // Projections: index 0 = X from +V1, index 1 = Y from -V3, index 2 = Z from -V2.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_proj
            localparam int SRC = (gi == 0) ? 0 : ((gi == 1) ? 2 : 1);
            logic signed [31:0] w_vext;
            assign w_vext = {{16{r_v[SRC][15]}}, r_v[SRC]};
            if (gi == 0) begin : g_pos
                assign w_prod[gi] = w_vext * P_S;
            end else begin : g_neg
                assign w_prod[gi] = -(w_vext * P_S);
            end
        end
    endgenerate

    always_comb begin
        w_t1_raw = '0;
        w_t2_raw = '0;
        case (r_n)
            3'd1: begin w_t1_raw = r_xyz[2];  w_t2_raw = r_xyz[1];  end
            3'd2: begin w_t1_raw = r_xyz[1];  w_t2_raw = -r_xyz[0]; end
            3'd3: begin w_t1_raw = -r_xyz[2]; w_t2_raw = r_xyz[0];  end
            3'd4: begin w_t1_raw = -r_xyz[0]; w_t2_raw = r_xyz[2];  end
            3'd5: begin w_t1_raw = r_xyz[0];  w_t2_raw = -r_xyz[1]; end
            3'd6: begin w_t1_raw = -r_xyz[1]; w_t2_raw = -r_xyz[2]; end
            default: ;
        endcase
    end

    assign w_t1_c = (w_t1_raw < 0) ? 16'd0 : w_t1_raw[15:0];
    assign w_t2_c = (w_t2_raw < 0) ? 16'd0 : w_t2_raw[15:0];
    assign w_sum  = {1'b0, w_t1_c} + {1'b0, w_t2_c};
    assign w_ovm  = (w_sum > {1'b0, PERIOD});

`ifdef SVPWM_OVM_SCALE_EN
    // Quotient is bounded by T1 < 2^16, so the upper numerator half always starts below the divisor.
    assign w_num          = {16'd0, w_t1_c} * {16'd0, PERIOD};
    assign w_div_trial    = {r_div_rem, r_div_num[15]};
    assign w_div_diff     = w_div_trial - {1'b0, r_div_den};
    assign w_div_ge       = ~w_div_diff[17];
    assign w_div_rem_next = w_div_ge ? w_div_diff[16:0] : w_div_trial[16:0];
    assign w_div_quo_next = {r_div_quo, w_div_ge};
`else
    assign w_t1_min = (w_t1_c > PERIOD) ? PERIOD : w_t1_c;
`endif

    assign w_ta = (PERIOD - r_t1 - r_t2) >> 2;
    assign w_tb = w_ta + (r_t1 >> 1);
    assign w_tc = w_tb + (r_t2 >> 1);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_next = S_MULT;
            S_MULT: w_state_next = S_SEL;
`ifdef SVPWM_OVM_SCALE_EN
            S_SEL:  w_state_next = w_ovm ? S_DIV : S_CMP;
            S_DIV:  if (r_div_cnt == 4'd15) w_state_next = S_CMP;
`else
            S_SEL:  w_state_next = S_CMP;
`endif
            S_CMP:  w_state_next = S_OUT;
            S_OUT:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_en_prev <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_v[k]   <= '0;
                r_xyz[k] <= '0;
            end
            r_n      <= '0;
            r_t1     <= '0;
            r_t2     <= '0;
            r_ta     <= '0;
            r_tb     <= '0;
            r_tc     <= '0;
            r_tcm1   <= '0;
            r_tcm2   <= '0;
            r_tcm3   <= '0;
            r_sector <= '0;
            r_done   <= 1'b0;
`ifdef SVPWM_OVM_SCALE_EN
            r_div_rem <= '0;
            r_div_num <= '0;
            r_div_den <= '0;
            r_div_quo <= '0;
            r_div_cnt <= '0;
`endif
        end else begin
            r_en_prev <= bus.iSV_en;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_v[0] <= bus.iV1;
                        r_v[1] <= bus.iV2;
                        r_v[2] <= bus.iV3;
                        r_n    <= {bus.iV3 > 16'sd0, bus.iV2 > 16'sd0, bus.iV1 > 16'sd0};
                    end
                end
                S_MULT: begin
                    for (int k = 0; k < 3; k++) begin
                        r_xyz[k] <= w_prod[k] >>> 15;
                    end
                end
                S_SEL: begin
                    r_t1 <= w_t1_c;
                    r_t2 <= w_t2_c;
                    if (w_ovm) begin
`ifdef SVPWM_OVM_SCALE_EN
                        r_div_rem <= {1'b0, w_num[31:16]};
                        r_div_num <= w_num[15:0];
                        r_div_den <= w_sum;
                        r_div_quo <= '0;
                        r_div_cnt <= '0;
`else
                        r_t1 <= w_t1_min;
                        r_t2 <= PERIOD - w_t1_min;
`endif
                    end
                end
`ifdef SVPWM_OVM_SCALE_EN
                S_DIV: begin
                    r_div_rem <= w_div_rem_next;
                    r_div_num <= {r_div_num[14:0], 1'b0};
                    r_div_quo <= w_div_quo_next[14:0];
                    r_div_cnt <= r_div_cnt + 4'd1;
                    if (r_div_cnt == 4'd15) begin
                        r_t1 <= w_div_quo_next;
                        r_t2 <= PERIOD - w_div_quo_next;
                    end
                end
`endif
                S_CMP: begin
                    r_ta <= w_ta;
                    r_tb <= w_tb;
                    r_tc <= w_tc;
                end
                S_OUT: begin
                    case (r_n)
                        3'd1: begin r_tcm1 <= r_tb; r_tcm2 <= r_ta; r_tcm3 <= r_tc; end
                        3'd2: begin r_tcm1 <= r_ta; r_tcm2 <= r_tc; r_tcm3 <= r_tb; end
                        3'd3: begin r_tcm1 <= r_ta; r_tcm2 <= r_tb; r_tcm3 <= r_tc; end
                        3'd4: begin r_tcm1 <= r_tc; r_tcm2 <= r_tb; r_tcm3 <= r_ta; end
                        3'd5: begin r_tcm1 <= r_tc; r_tcm2 <= r_ta; r_tcm3 <= r_tb; end
                        3'd6: begin r_tcm1 <= r_tb; r_tcm2 <= r_tc; r_tcm3 <= r_ta; end
                        default: begin r_tcm1 <= r_ta; r_tcm2 <= r_ta; r_tcm3 <= r_ta; end
                    endcase
                    r_sector <= r_n;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.oTcm1    = r_tcm1;
    assign bus.oTcm2    = r_tcm2;
    assign bus.oTcm3    = r_tcm3;
    assign bus.oSector  = r_sector;
    assign bus.oSV_done = r_done;

endmodule

// File: tb/tb_svpwm_calc.sv
// Directed bench for svpwm_calc (PERIOD = 5000): vector table for each sector plus
// hand-written start-edge and mid-calculation reset sequences.
module tb_svpwm_calc;

    logic iClk   = 1'b0;
    logic iRst_n = 1'b1;

    svpwm_calc_if sv_if ();

    svpwm_calc #(.PERIOD(16'd5000)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (sv_if)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int v1;
        int v2;
        int v3;
        int n;
        int t1;
        int t2;
        int t3;
        int lat;
    } vec_t;

    vec_t vecs [9];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Rising edge sampled at the next posedge (cycle 0); latency counted in posedges after it.
    task automatic pulse_and_wait(input int v1, input int v2, input int v3, output int lat);
        @(negedge iClk);
        sv_if.iV1    = 16'(v1);
        sv_if.iV2    = 16'(v2);
        sv_if.iV3    = 16'(v3);
        sv_if.iSV_en = 1'b1;
        @(posedge iClk);
        #1;
        sv_if.iSV_en = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge iClk);
            #1;
            if (sv_if.oSV_done) begin
                lat = c;
                break;
            end
        end
    endtask

    // Bit c of en_pat is the iSV_en level sampled at posedge c; returns the number of done pulses.
    task automatic drive_seq(input logic [63:0] en_pat, input int cycles, output int dones);
        dones = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge iClk);
            sv_if.iSV_en = (c < 64) ? en_pat[c] : 1'b0;
            @(posedge iClk);
            #1;
            if (sv_if.oSV_done) dones++;
        end
        @(negedge iClk);
        sv_if.iSV_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected $finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int dones;

        vecs[0] = '{0,      0,      0,      0, 1250, 1250, 1250, 4};
        vecs[1] = '{0,      14189,  -14189, 2, 708,  1790, 1790, 4};
        vecs[2] = '{30000,  -15000, -15000, 1, 1250, 106,  2394, 4};
`ifdef SVPWM_OVM_SCALE_EN
        vecs[3] = '{32767,  -30000, -30000, 1, 1250, 0,    2500, 20};
`else
        vecs[3] = '{32767,  -30000, -30000, 1, 2288, 0,    2499, 4};
`endif
        vecs[4] = '{0,      -14189, 14189,  4, 1790, 708,  708,  4};
        vecs[5] = '{10000,  5000,   -5000,  3, 678,  1059, 1821, 4};
        vecs[6] = '{1000,   1000,   1000,   7, 1250, 1250, 1250, 4};
        vecs[7] = '{10000,  -5000,  5000,   5, 1821, 678,  1440, 4};
        vecs[8] = '{-10000, 5000,   5000,   6, 1249, 1630, 868,  4};

        sv_if.iSV_en = 1'b0;
        sv_if.iV1    = '0;
        sv_if.iV2    = '0;
        sv_if.iV3    = '0;

        #2 iRst_n = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        check("rst_tcm1", 0, int'(sv_if.oTcm1), 0);
        check("rst_tcm2", 0, int'(sv_if.oTcm2), 0);
        check("rst_tcm3", 0, int'(sv_if.oTcm3), 0);
        check("rst_sector", 0, int'(sv_if.oSector), 0);
        check("rst_done", 0, int'(sv_if.oSV_done), 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        repeat (2) @(posedge iClk);

        for (int i = 0; i < 9; i++) begin
            pulse_and_wait(vecs[i].v1, vecs[i].v2, vecs[i].v3, lat);
            $display("[TB] vec %0d: V=%0d,%0d,%0d N=%0d Tcm=%0d,%0d,%0d latency=%0d", i,
                     vecs[i].v1, vecs[i].v2, vecs[i].v3, sv_if.oSector,
                     sv_if.oTcm1, sv_if.oTcm2, sv_if.oTcm3, lat);
            check("latency", i, lat, vecs[i].lat);
            check("sector", i, int'(sv_if.oSector), vecs[i].n);
            check("tcm1", i, int'(sv_if.oTcm1), vecs[i].t1);
            check("tcm2", i, int'(sv_if.oTcm2), vecs[i].t2);
            check("tcm3", i, int'(sv_if.oTcm3), vecs[i].t3);
            if (lat > 0) begin
                @(posedge iClk);
                #1;
                check("done_width", i, int'(sv_if.oSV_done), 0);
            end
        end

        @(negedge iClk);
        sv_if.iV1 = 16'(vecs[2].v1);
        sv_if.iV2 = 16'(vecs[2].v2);
        sv_if.iV3 = 16'(vecs[2].v3);

        drive_seq(64'h0000_0000_3FFF_FFFF, 45, dones);
        $display("[TB] seq held-high 30 cycles: done pulses=%0d", dones);
        check("held_high_dones", 0, dones, 1);

        drive_seq(64'h5, 30, dones);
        $display("[TB] seq edge at cycle 2 (mid-calc): done pulses=%0d", dones);
        check("midcalc_dones", 0, dones, 1);
        check("midcalc_tcm2", 0, int'(sv_if.oTcm2), 106);

        drive_seq(64'h9, 30, dones);
        $display("[TB] seq edge at cycle 3 (mid-calc): done pulses=%0d", dones);
        check("midcalc3_dones", 0, dones, 1);

        drive_seq(64'h0000_0000_001F_FFF1, 40, dones);
        $display("[TB] seq edge coinciding with OUT: done pulses=%0d", dones);
        check("out_edge_dones", 0, dones, 1);

        drive_seq(64'h41, 30, dones);
        $display("[TB] seq second edge after IDLE: done pulses=%0d", dones);
        check("restart_dones", 0, dones, 2);

        @(negedge iClk);
        sv_if.iSV_en = 1'b1;
        @(posedge iClk);
        #1;
        sv_if.iSV_en = 1'b0;
        @(posedge iClk);
        @(posedge iClk);
        #1;
        iRst_n = 1'b0;
        #1;
        $display("[TB] reset two cycles after start: Tcm=%0d,%0d,%0d N=%0d done=%0d",
                 sv_if.oTcm1, sv_if.oTcm2, sv_if.oTcm3, sv_if.oSector, sv_if.oSV_done);
        check("midrst_tcm1", 0, int'(sv_if.oTcm1), 0);
        check("midrst_tcm2", 0, int'(sv_if.oTcm2), 0);
        check("midrst_tcm3", 0, int'(sv_if.oTcm3), 0);
        check("midrst_sector", 0, int'(sv_if.oSector), 0);
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        iRst_n = 1'b1;
        drive_seq(64'h0, 25, dones);
        $display("[TB] after reset release: done pulses=%0d Tcm1=%0d", dones, sv_if.oTcm1);
        check("postrst_dones", 0, dones, 0);
        check("postrst_tcm1", 0, int'(sv_if.oTcm1), 0);

        pulse_and_wait(vecs[2].v1, vecs[2].v2, vecs[2].v3, lat);
        $display("[TB] restart after reset: N=%0d Tcm=%0d,%0d,%0d latency=%0d",
                 sv_if.oSector, sv_if.oTcm1, sv_if.oTcm2, sv_if.oTcm3, lat);
        check("rerun_latency", 0, lat, 4);
        check("rerun_sector", 0, int'(sv_if.oSector), 1);
        check("rerun_tcm1", 0, int'(sv_if.oTcm1), 1250);
        check("rerun_tcm2", 0, int'(sv_if.oTcm2), 106);
        check("rerun_tcm3", 0, int'(sv_if.oTcm3), 2394);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/svpwm_calc.md
SVPWM_CALC -- requirements
Module: svpwm_calc

Interface
REQ-001 SHALL have parameter PERIOD, default 16'd5000, giving the full PWM period in counter ticks (up-down counter peak = PERIOD/2).
REQ-002 SHALL have port iClk, input, 1 bit: the single clock.
REQ-003 SHALL have port iRst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port iSV_en, input, 1 bit: start request, acted on at its rising edge.
REQ-005 SHALL have ports iV1, iV2, iV3, input, 16 bits signed each: inverse-Clarke phase references, where 32767 = Vdc/sqrt(3).
REQ-006 SHALL have ports oTcm1, oTcm2, oTcm3, output, 16 bits unsigned each: phase A/B/C compare values.
REQ-007 SHALL have port oSector, output, 3 bits: the sector code N of the last result.
REQ-008 SHALL have port oSV_done, output, 1 bit: one-cycle result-valid pulse.

Function
REQ-009 SHALL register iSV_en every cycle and start only when the previous sample is 0 and the current sample is 1; a level held high SHALL NOT retrigger.
REQ-010 SHALL implement the states IDLE -> MULT -> SEL -> [DIV] -> CMP -> OUT -> IDLE, and rising edges seen outside IDLE SHALL be ignored.
REQ-011 IDLE SHALL latch iV1..iV3 on a start edge and SHALL compute N = (iV1>0) + 2*(iV2>0) + 4*(iV3>0).
REQ-012 MULT SHALL compute X = (V1*PERIOD)>>>15, Y = (-V3*PERIOD)>>>15 and Z = (-V2*PERIOD)>>>15, using 32-bit signed products.
REQ-013 SEL SHALL choose T1,T2 by N as follows: N=1 gives Z,Y; N=2 gives Y,-X; N=3 gives -Z,X; N=4 gives -X,Z; N=5 gives X,-Y; N=6 gives -Y,-Z.
REQ-014 SEL SHALL set T1 = T2 = 0 when N = 0 or N = 7 (zero vector).
REQ-015 SEL SHALL clamp any negative T1 or T2 to 0.
REQ-016 SHALL treat the case T1+T2 > PERIOD as overmodulation and handle it per REQ-025/026; otherwise DIV SHALL be skipped.
REQ-017 CMP SHALL compute Ta = (PERIOD-T1-T2)>>2, Tb = Ta + (T1>>1) and Tc = Tb + (T2>>1), all unsigned.
REQ-018 OUT SHALL map the compare values (oTcm1,oTcm2,oTcm3) by N as follows: N=1 gives Tb,Ta,Tc; N=2 gives Ta,Tc,Tb; N=3 gives Ta,Tb,Tc; N=4 gives Tc,Tb,Ta; N=5 gives Tc,Ta,Tb; N=6 gives Tb,Tc,Ta; N=0 or N=7 gives Ta,Ta,Ta.
REQ-019 OUT SHALL update oSector and pulse oSV_done high for exactly one cycle.
REQ-020 Latency SHALL be 4 cycles from the start-edge clock to the oSV_done cycle without DIV, and 20 cycles with DIV.
REQ-021 Outputs SHALL hold their values between results.
REQ-022 A start edge sampled in the same cycle that OUT completes SHALL be ignored; the next start requires a fresh edge once the block is in IDLE.

Reset
REQ-023 On iRst_n low, all outputs and oSV_done SHALL go to 0 immediately.
REQ-024 On iRst_n low, the state SHALL return to IDLE, the enable history SHALL clear to 0, and any calculation in progress SHALL be discarded without a done pulse.

Configuration
REQ-025 With SVPWM_OVM_SCALE_EN defined, overmodulation SHALL enter DIV: a 16-cycle restoring divider SHALL compute T1' = floor(T1*PERIOD/(T1+T2)), with T2' = PERIOD - T1'.
REQ-026 With SVPWM_OVM_SCALE_EN undefined, the DIV state and divider SHALL be absent; overmodulation SHALL set T1' = min(T1,PERIOD) and T2' = PERIOD - T1' within SEL, so latency stays 4 cycles.

Verification (PERIOD = 5000)
REQ-027 V1=0, V2=0, V3=0, pulse en -> N=0; Tcm = 1250, 1250, 1250; done after 4 cycles.
REQ-028 V1=0, V2=14189, V3=-14189 -> N=2; T1=2165, T2=0; Tcm = 708, 1790, 1790.
REQ-029 V1=30000, V2=-15000, V3=-15000 -> N=1; T1=T2=2288; Tcm = 1250, 106, 2394.
REQ-030 V1=32767, V2=-30000, V3=-30000 -> N=1, overmodulation; with macro Tcm = 1250, 0, 2500 and done at cycle 20; without macro Tcm = 2288, 0, 2499 and done at cycle 4.
REQ-031 iSV_en held high for 30 cycles -> exactly one done pulse; a second rising edge issued mid-calculation -> ignored.
REQ-032 iRst_n asserted two cycles after start -> outputs stay 0 and no done pulse; the next start edge after release -> normal result.
